// File: rtl/agnus_sprite_dma_sched.sv
// Sprite DMA slot scheduler: eight sprite fetch lists, one chip-bus read in flight,
// acknowledged words forwarded to the sprite shifters as POS/CTL/DATA/DATB writes.
module agnus_sprite_dma_sched #(
  parameter logic [7:0]  SLOT_BASE  = 8'h15,
  parameter logic [10:0] VSPR_START = 11'd25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cck_en,
  input  logic [7:0]  cck,
  input  logic [10:0] vpos,
  input  logic        sprdma_en,
  input  logic [1:0]  fmode,
  input  logic        ptr_we,
  input  logic [2:0]  ptr_sel,
  input  logic        ptr_hi,
  input  logic [15:0] ptr_data,
  output logic        dma_req,
  output logic [19:0] dma_addr,
  input  logic        dma_ack,
  input  logic [15:0] dma_rdata,
  output logic        spr_aen,
  output logic [2:0]  spr_sel,
  output logic [1:0]  spr_reg,
  output logic [15:0] spr_data
);

  // state | meaning
  // CTL   | slot A fetches POS, slot B fetches CTL
  // WAIT  | idle until line start with vpos == vstart
  // DATA  | slot A fetches DATA, slot B fetches DATB until vpos == vstop
  // DONE  | idle until the list restarts on VSPR_START
  typedef enum logic [1:0] {ST_CTL = 2'd0, ST_WAIT, ST_DATA, ST_DONE} spr_state_t;

  localparam logic [1:0] REG_POS = 2'b00;
  localparam logic [1:0] REG_CTL = 2'b01;

  logic [1:0]  rst_pipe;
  logic        rst_sync_n;

  spr_state_t  state     [8];
  spr_state_t  state_nxt [8];
  logic [19:0] ptr       [8];
  logic [8:0]  vstart    [8];
  logic [8:0]  vstop     [8];
  logic [15:0] pos_word;

  logic        out_valid;
  logic [2:0]  out_sel;
  logic [1:0]  out_reg;

  logic [7:0]  slot_off;
  logic        slot_hit;
  logic        slot_b;
  logic [2:0]  slot_spr;
  logic        line_start;
  logic        restart;
  logic        ack_take;
  logic        ctl_ack;
  logic        fetch;
  logic [1:0]  fetch_reg;
  logic [19:0] ptr_inc;
  logic        unused_bits;

  // Assertion is immediate, release is delayed two clocks to stay clear of recovery.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_sync_n = rst_pipe[1];

  assign slot_off   = cck - SLOT_BASE;
  assign slot_hit   = cck_en && (slot_off < 8'd32) && !slot_off[0];
  assign slot_spr   = slot_off[4:2];
  assign slot_b     = slot_off[1];
  assign line_start = cck_en && (cck == 8'd0);
  assign restart    = line_start && (vpos == VSPR_START);
  assign ack_take   = out_valid && dma_ack;
  assign ctl_ack    = ack_take && (out_reg == REG_CTL);
  assign unused_bits = ptr_data[0];

  always_comb begin
    case (fmode)
      2'b00:   ptr_inc = 20'd1;
      2'b11:   ptr_inc = 20'd4;
      default: ptr_inc = 20'd2;
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      for (int i = 0; i < 8; i++) state[i] <= ST_DONE;
    end else begin
      for (int i = 0; i < 8; i++) state[i] <= state_nxt[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      state_nxt[i] = state[i];
      if (ctl_ack && out_sel == 3'(i) && state[i] == ST_CTL)
        state_nxt[i] = (pos_word == 16'd0 && dma_rdata == 16'd0) ? ST_DONE : ST_WAIT;
      // vstop wins over vstart so a one-line sprite still terminates.
      if (restart) begin
        state_nxt[i] = ST_CTL;
      end else if (line_start) begin
        if (state[i] == ST_DATA && vpos[8:0] == vstop[i])
          state_nxt[i] = ST_CTL;
        else if (state[i] == ST_WAIT && vpos[8:0] == vstart[i])
          state_nxt[i] = ST_DATA;
      end
    end
  end

  always_comb begin
    fetch     = 1'b0;
    fetch_reg = REG_POS;
    if (slot_hit && sprdma_en) begin
      if (state[slot_spr] == ST_CTL) begin
        fetch     = 1'b1;
        fetch_reg = {1'b0, slot_b};
      end else if (state[slot_spr] == ST_DATA) begin
        fetch     = 1'b1;
        fetch_reg = {1'b1, slot_b};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      dma_req   <= 1'b0;
      dma_addr  <= '0;
      out_valid <= 1'b0;
      out_sel   <= '0;
      out_reg   <= '0;
      spr_aen   <= 1'b0;
      spr_sel   <= '0;
      spr_reg   <= '0;
      spr_data  <= '0;
      pos_word  <= '0;
      for (int i = 0; i < 8; i++) begin
        ptr[i]    <= '0;
        vstart[i] <= '0;
        vstop[i]  <= '0;
      end
    end else begin
      dma_req <= fetch;
      spr_aen <= ack_take;
      // Any slot retires an unanswered fetch; a new fetch simply replaces it.
      if (fetch) begin
        dma_addr  <= ptr[slot_spr];
        out_valid <= 1'b1;
        out_sel   <= slot_spr;
        out_reg   <= fetch_reg;
      end else if (ack_take || slot_hit) begin
        out_valid <= 1'b0;
      end
      if (ack_take) begin
        spr_sel  <= out_sel;
        spr_reg  <= out_reg;
        spr_data <= dma_rdata;
        if (out_reg == REG_POS) pos_word <= dma_rdata;
      end
      for (int i = 0; i < 8; i++) begin
        // PTH holds word-address bits 19:15, PTL bits 14:0 (byte bit 0 dropped).
        if (ptr_we && ptr_sel == 3'(i)) begin
          if (ptr_hi) ptr[i][19:15] <= ptr_data[4:0];
          else        ptr[i][14:0]  <= ptr_data[15:1];
        end else if (fetch && slot_spr == 3'(i)) begin
          ptr[i] <= ptr[i] + ptr_inc;
        end
        if (ctl_ack && out_sel == 3'(i) && state[i] == ST_CTL) begin
          vstart[i] <= {dma_rdata[2], pos_word[15:8]};
          vstop[i]  <= {dma_rdata[1], dma_rdata[15:8]};
        end
      end
    end
  end

endmodule

// File: doc/agnus_sprite_dma_sched.md
AGNUS_SPRITE_DMA_SCHED -- requirements
Module: agnus_sprite_dma_sched

Interface
REQ-001 The block SHALL have parameter SLOT_BASE, default 8'h15, giving the colour-clock slot of sprite 0 fetch A.
REQ-002 The block SHALL have parameter VSPR_START, default 11'd25, giving the line on which all sprite lists restart.
REQ-003 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  28 MHz clock, the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- cck_en  in  1  one-cycle pulse per colour clock; slots are evaluated only when it is high.
- cck  in  8  colour-clock counter for the current line; 0 means line start.
- vpos  in  11  current line number.
- sprdma_en  in  1  DMACON DMAEN & SPREN.
- fmode  in  2  sprite fetch width: 00 = 16 bit, 01/10 = 32 bit, 11 = 64 bit.
- ptr_we, ptr_sel, ptr_hi, ptr_data  in  1/3/1/16  CPU write to SPRxPTH (ptr_hi=1) or SPRxPTL.
- dma_req  out  1  one-cycle chip-bus read request.
- dma_addr  out  20  word address [20:1].
- dma_ack  in  1  read data valid.
- dma_rdata  in  16  read data.
- spr_aen  out  1  one-cycle register-write strobe to the sprite shifters.
- spr_sel  out  3  target sprite.
- spr_reg  out  2  00 = POS, 01 = CTL, 10 = DATA, 11 = DATB.
- spr_data  out  16  write data.

Function
REQ-004 Slot A of sprite n SHALL be cck == SLOT_BASE+4n, and slot B SHALL be SLOT_BASE+4n+2, each qualified by cck_en.
REQ-005 Each sprite SHALL hold a 20-bit pointer, a 9-bit vstart, a 9-bit vstop and a state in {CTL, WAIT, DATA, DONE}.
REQ-006 In CTL, slot A SHALL fetch POS and slot B SHALL fetch CTL.
- On the CTL ack: vstart = {ctl[2], pos[15:8]} and vstop = {ctl[1], ctl[15:8]}.
- If both words are zero the sprite SHALL go to DONE; otherwise it SHALL go to WAIT.
REQ-007 In WAIT, the sprite SHALL issue no fetch. At a line start, vpos[8:0] == vstart SHALL move it to DATA, which takes effect on that same line.
REQ-008 In DATA, slot A SHALL fetch DATA and slot B SHALL fetch DATB. At a line start, vpos[8:0] == vstop SHALL move it to CTL, with the POS/CTL fetch on that same line; vstop is checked before vstart.
REQ-009 In DONE, the sprite SHALL issue no fetch until the list restarts.
REQ-010 At a line start with vpos == VSPR_START, all eight sprites SHALL enter CTL, overriding REQ-007 and REQ-008.
REQ-011 Each fetch SHALL issue dma_req with dma_addr = pointer on the clk after the slot.
REQ-012 Each fetch SHALL advance the pointer by 1, 2 or 4 words for fmode 00, 01/10 or 11; the pointer wraps modulo 2^20.
REQ-013 A CPU pointer write SHALL replace the addressed half. If it coincides with a DMA increment of the same sprite, the CPU value SHALL win and the increment SHALL be discarded.
REQ-014 At most one fetch SHALL be outstanding.
- The first dma_ack after dma_req completes it.
- A dma_ack with nothing outstanding SHALL be ignored.
- A fetch still unacknowledged at the next slot SHALL be dropped: no state change, no spr_aen, pointer already advanced. The new slot then proceeds normally.
REQ-015 Each acknowledged fetch SHALL produce spr_aen on the clk after dma_ack, with the matching spr_sel/spr_reg and spr_data = dma_rdata.
REQ-016 POS and CTL words SHALL be forwarded before the CTL-state decision, so the shifter disarms on CTL.
REQ-017 When sprdma_en is 0 at a slot, the slot SHALL be skipped: no request, and the state and pointer unchanged. Line-start transitions SHALL still occur.

Reset
REQ-018 While reset_n is 0, all sprites SHALL be DONE; pointers, vstart and vstop SHALL be 0; dma_req, spr_aen, spr_sel, spr_reg and spr_data SHALL be 0; nothing SHALL be outstanding.
REQ-019 Deassertion of reset_n SHALL be synchronised to clk. A reset mid-fetch SHALL abandon the fetch, and a later stale dma_ack SHALL be ignored.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Sprite 0 pointer = 0x01000, fmode = 00, line 25. Required: reads at 0x01000 and 0x01001 in slots 0x15 and 0x17; spr_aen POS then CTL; pointer = 0x01002.
- POS = 0x3040, CTL = 0x3200. Required: WAIT; DATA/DATB fetched on lines 0x30 and 0x31; line 0x32 fetches the next POS/CTL and no data.
- POS = CTL = 0 fetched. Required: DONE; no further dma_req for that sprite until vpos = 25.
- fmode = 11, sprite 3 in DATA. Required: fetches in slots 0x21 and 0x23; pointer +8 per line.
- dma_ack withheld past the next slot. Required: no spr_aen, state unchanged; the next slot is issued normally.
- CPU SPR2PTL write in the same clk as a sprite 2 fetch increment. Required: pointer equals the CPU value; sprdma_en = 0 produces no dma_req.
